// File: rtl/or1200_fpu_arb.sv
// Round-robin arbiter/sequencer sharing one FPU core between two requesters.
// Holds the accepted operation on the FPU until done or watchdog expiry, then returns the response to its owner.
module or1200_fpu_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_flag,
  output logic        rsp_exc,
  output logic        rsp_err,
  output logic [7:0]  fpu_op_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  input  logic [31:0] fpu_result_i,
  input  logic        fpu_done_i,
  input  logic        fpu_flag_i,
  input  logic        fpu_sig_i,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
  // valid must not depend on ready, and payload is sampled at that clock edge.

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          rr, rr_nxt;
  logic          owner, owner_nxt;
  logic [7:0]    op_q, op_nxt;
  logic [31:0]   a_q, a_nxt;
  logic [31:0]   b_q, b_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   res_q, res_nxt;
  logic          flag_q, flag_nxt;
  logic          exc_q, exc_nxt;
  logic          err_q, err_nxt;
  logic          busy_q;

  logic          both_valid;
  logic          grant;
  logic          accept;
  logic          rsp_take;
  logic [7:0]    sel_op;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;

  assign both_valid = req0_valid & req1_valid;
  assign grant      = both_valid ? rr : req1_valid;
  // rst gates the grant so ready is forced low while reset is asserted
  assign accept     = rst & (state == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;
  assign sel_op     = grant ? req1_op : req0_op;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    owner_nxt = owner;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    cnt_nxt   = cnt;
    res_nxt   = res_q;
    flag_nxt  = flag_q;
    exc_nxt   = exc_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          owner_nxt = grant;
          rr_nxt    = ~grant;
          op_nxt    = sel_op;
          a_nxt     = sel_a;
          b_nxt     = sel_b;
          cnt_nxt   = '0;
          if (sel_op[7]) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = RESP;
            res_nxt   = '0;
            flag_nxt  = 1'b0;
            exc_nxt   = 1'b0;
            err_nxt   = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CW'(1);
        // done has priority over a watchdog expiry in the same cycle
        if (fpu_done_i) begin
          state_nxt = RESP;
          res_nxt   = fpu_result_i;
          flag_nxt  = fpu_flag_i;
          exc_nxt   = fpu_sig_i;
          err_nxt   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          res_nxt   = '0;
          flag_nxt  = 1'b0;
          exc_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      exc_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr     <= rr_nxt;
      owner  <= owner_nxt;
      op_q   <= op_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      cnt    <= cnt_nxt;
      res_q  <= res_nxt;
      flag_q <= flag_nxt;
      exc_q  <= exc_nxt;
      err_q  <= err_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  assign fpu_op_o   = (state == BUSY) ? op_q : '0;
  assign fpu_a_o    = (state == BUSY) ? a_q : '0;
  assign fpu_b_o    = (state == BUSY) ? b_q : '0;
  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp_result = res_q;
  assign rsp_flag   = flag_q;
  assign rsp_exc    = exc_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_or1200_fpu_arb.sv
// Bench for or1200_fpu_arb: directed vector table, hand-written corner sequences and
// random traffic checked against a transaction-level timing model with an expected queue.
module tb_or1200_fpu_arb;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_flag, rsp_exc, rsp_err;
  logic [7:0]  fpu_op_o;
  logic [31:0] fpu_a_o, fpu_b_o, fpu_result_i;
  logic        fpu_done_i, fpu_flag_i, fpu_sig_i;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  or1200_fpu_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_exc(rsp_exc), .rsp_err(rsp_err),
    .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_result_i(fpu_result_i), .fpu_done_i(fpu_done_i), .fpu_flag_i(fpu_flag_i), .fpu_sig_i(fpu_sig_i),
    .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // pending request per requester; plat < 0 means the FPU never answers
  logic        pv[2];
  logic [7:0]  pop[2];
  logic [31:0] pa[2], pb[2], pres[2];
  logic        pflag[2], psig[2];
  int          plat[2];
  int          rdy_pct = 100;
  int          noise = 1;

  // transaction-level model of the operation in flight
  bit          m_active = 0;
  int          m_owner, m_acc, m_due, m_lat;
  int          m_rr = 0;
  logic        m_legal;
  logic [7:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_flag, m_sig;
  logic [35:0] exp_q[$];
  int          grant_q[$];

  int          last_acc, last_owner, first_valid, last_hs;
  bit          seen_valid = 0;
  logic [31:0] hs_result;
  logic        hs_err, hs_flag, hs_exc;

  typedef struct {
    int          req;
    logic [7:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] fres;
    logic        fflag, fsig;
    logic        exp_err;
    logic [31:0] exp_result;
    logic        exp_flag, exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    req0_valid = pv[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pv[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
    if (m_active && m_legal && cyc < m_due) begin
      fpu_done_i   = (m_lat >= 0) && (cyc == m_acc + 1 + m_lat);
      fpu_result_i = m_res;
      fpu_flag_i   = m_flag;
      fpu_sig_i    = m_sig;
    end else begin
      fpu_done_i   = (noise == 2) ? 1'b1 : ((noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      fpu_result_i = $urandom;
      fpu_flag_i   = 1'($urandom);
      fpu_sig_i    = 1'($urandom);
    end
    rsp0_ready = (m_active && m_owner == 0) ? ($urandom_range(0, 99) < rdy_pct) : 1'($urandom_range(0, 1));
    rsp1_ready = (m_active && m_owner == 1) ? ($urandom_range(0, 99) < rdy_pct) : 1'($urandom_range(0, 1));
  endtask

  task automatic check_update();
    bit in_resp, in_busy, any, timed_out;
    int g;
    logic [35:0] e;
    in_resp = m_active && (cyc >= m_due);
    in_busy = m_active && !in_resp && m_legal;
    any     = !m_active && (pv[0] || pv[1]);
    g       = (pv[0] && pv[1]) ? m_rr : (pv[1] ? 1 : 0);
    chk("busy", 64'(busy), 64'(m_active));
    chk("fpu_op", 64'(fpu_op_o), 64'(in_busy ? m_op : 8'h00));
    if (in_busy) begin
      chk("fpu_a", 64'(fpu_a_o), 64'(m_a));
      chk("fpu_b", 64'(fpu_b_o), 64'(m_b));
    end
    chk("req0_ready", 64'(req0_ready), 64'(any && g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(any && g == 1));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(in_resp && m_owner == 0));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(in_resp && m_owner == 1));
    if (in_resp && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("rsp_err", 64'(rsp_err), 64'(e[34]));
      chk("rsp_flag", 64'(rsp_flag), 64'(e[33]));
      chk("rsp_exc", 64'(rsp_exc), 64'(e[32]));
      chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
    end
    if ((rsp0_valid || rsp1_valid) && !seen_valid) begin
      seen_valid  = 1;
      first_valid = cyc;
    end
    if (in_resp && ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready))) begin
      m_active  = 0;
      last_hs   = cyc;
      hs_result = rsp_result;
      hs_err    = rsp_err;
      hs_flag   = rsp_flag;
      hs_exc    = rsp_exc;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (any) begin
      m_active  = 1;
      m_owner   = g;
      m_acc     = cyc;
      m_rr      = 1 - g;
      m_op      = pop[g];
      m_a       = pa[g];
      m_b       = pb[g];
      m_lat     = plat[g];
      m_res     = pres[g];
      m_flag    = pflag[g];
      m_sig     = psig[g];
      m_legal   = m_op[7];
      timed_out = (m_lat < 0) || (m_lat >= TIMEOUT);
      if (!m_legal) begin
        m_due = cyc + 1;
        exp_q.push_back({1'(g), 1'b1, 1'b0, 1'b0, 32'h0});
      end else if (timed_out) begin
        m_due = cyc + TIMEOUT + 1;
        exp_q.push_back({1'(g), 1'b1, 1'b0, 1'b0, 32'h0});
      end else begin
        m_due = cyc + 2 + m_lat;
        exp_q.push_back({1'(g), 1'b0, m_flag, m_sig, m_res});
      end
      grant_q.push_back(g);
      last_acc   = cyc;
      last_owner = g;
      seen_valid = 0;
      pv[g]      = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic new_req(input int n, input bit allow_bad);
    pv[n]    = 1'b1;
    pop[n]   = (allow_bad && $urandom_range(0, 9) == 0) ? {1'b0, 7'($urandom)} : {1'b1, 7'($urandom)};
    pa[n]    = $urandom;
    pb[n]    = $urandom;
    plat[n]  = (allow_bad && $urandom_range(0, 49) == 0) ? -1 : int'($urandom_range(0, 6));
    pres[n]  = $urandom;
    pflag[n] = 1'($urandom);
    psig[n]  = 1'($urandom);
  endtask

  task automatic drain();
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int i = 0; i < 300 && m_active; i++) step();
    chk("drain_bound", 64'(m_active), 64'(0));
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stalled");
  end

  initial begin
    tbl[0] = '{0, 8'h80, 32'h3FC00000, 32'h40000000, 5,  32'h40600000, 1'b0, 1'b0, 1'b0, 32'h40600000, 1'b0, 1'b0, 7};
    tbl[1] = '{0, 8'h03, 32'h12345678, 32'h9ABCDEF0, 0,  32'h55555555, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1};
    tbl[2] = '{1, 8'h81, 32'h00000001, 32'h00000002, -1, 32'h77777777, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 65};
    tbl[3] = '{1, 8'hC2, 32'h11111111, 32'h22222222, 0,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 2};
    tbl[4] = '{0, 8'h7F, 32'hFFFFFFFF, 32'h0000FFFF, 3,  32'hAAAAAAAA, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1};
    tbl[5] = '{1, 8'h80, 32'h40400000, 32'hC0000000, 62, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b1, 64};
    tbl[6] = '{0, 8'h80, 32'h01020304, 32'h05060708, 63, 32'h12121212, 1'b1, 1'b1, 1'b0, 32'h12121212, 1'b1, 1'b1, 65};
    tbl[7] = '{1, 8'h85, 32'hCAFEF00D, 32'h0F0F0F0F, 64, 32'h34343434, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 65};

    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pop[n] = '0; pa[n] = '0; pb[n] = '0; plat[n] = 0;
      pres[n] = '0; pflag[n] = 1'b0; psig[n] = 1'b0;
    end

    // reset state, with both requesters valid to show ready is held low
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 8'h80; req1_op = 8'h81;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fpu_result_i = '0; fpu_done_i = 1'b1; fpu_flag_i = 1'b0; fpu_sig_i = 1'b0;
    #7;
    chk("rst_fpu_op", 64'(fpu_op_o), 64'(0));
    chk("rst_fpu_a", 64'(fpu_a_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_rsp_flag_exc", 64'({rsp_flag, rsp_exc}), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // directed vectors; done held high whenever the FPU is not busy
    noise = 2;
    for (int t = 0; t < 8; t++) begin
      int n;
      pv[tbl[t].req]    = 1'b1;
      pop[tbl[t].req]   = tbl[t].op;
      pa[tbl[t].req]    = tbl[t].a;
      pb[tbl[t].req]    = tbl[t].b;
      plat[tbl[t].req]  = tbl[t].lat;
      pres[tbl[t].req]  = tbl[t].fres;
      pflag[tbl[t].req] = tbl[t].fflag;
      psig[tbl[t].req]  = tbl[t].fsig;
      n = 0;
      do begin
        step();
        n++;
      end while ((pv[tbl[t].req] || m_active) && n < 300);
      chk($sformatf("tbl%0d_bound", t), 64'(n < 300), 64'(1));
      chk($sformatf("tbl%0d_owner", t), 64'(last_owner), 64'(tbl[t].req));
      chk($sformatf("tbl%0d_latency", t), 64'(first_valid - last_acc), 64'(tbl[t].exp_lat));
      chk($sformatf("tbl%0d_err", t), 64'(hs_err), 64'(tbl[t].exp_err));
      chk($sformatf("tbl%0d_result", t), 64'(hs_result), 64'(tbl[t].exp_result));
      chk($sformatf("tbl%0d_flag_exc", t), 64'({hs_flag, hs_exc}), 64'({tbl[t].exp_flag, tbl[t].exp_exc}));
      repeat (3) step();
    end
    noise = 1;

    // backpressure: response held for 10 cycles while requester 1 waits
    rdy_pct = 0;
    pv[0] = 1'b1; pop[0] = 8'h83; pa[0] = 32'hA5A5A5A5; pb[0] = 32'h5A5A5A5A;
    plat[0] = 2; pres[0] = 32'h13579BDF; pflag[0] = 1'b1; psig[0] = 1'b1;
    for (int i = 0; i < 20 && !m_active; i++) step();
    chk("bp_accept0", 64'(m_active), 64'(1));
    new_req(1, 1'b0);
    for (int i = 0; i < 20 && !seen_valid; i++) step();
    chk("bp_rsp0_seen", 64'(seen_valid), 64'(1));
    repeat (10) step();
    rdy_pct = 100;
    begin
      int n0;
      n0 = grant_q.size();
      for (int i = 0; i < 30 && grant_q.size() == n0; i++) step();
      chk("bp_grant1", 64'(grant_q.size() > n0 && last_owner == 1), 64'(1));
      chk("bp_grant_spacing", 64'(last_acc - last_hs), 64'(1));
    end
    drain();

    // reset in the third BUSY cycle of a requester-0 operation
    pv[0] = 1'b1; pop[0] = 8'h90; pa[0] = 32'h1; pb[0] = 32'h2; plat[0] = -1;
    for (int i = 0; i < 20 && !m_active; i++) step();
    chk("mid_accept", 64'(m_active && m_owner == 0), 64'(1));
    for (int i = 0; i < 10 && cyc < m_acc + 3; i++) step();
    chk("mid_third_busy", 64'(cyc), 64'(m_acc + 3));
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_fpu_op", 64'(fpu_op_o), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_valids", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    chk("mid_readys", 64'({req0_ready, req1_ready}), 64'(0));
    m_active = 0; m_rr = 0; seen_valid = 0;
    exp_q.delete();
    pv[0] = 1'b0; pv[1] = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("mid_hold_busy", 64'(busy), 64'(0));
    rst = 1'b1;

    // fairness: both requesters continuously valid for four operations
    grant_q.delete();
    begin
      int n;
      n = 0;
      do begin
        for (int r = 0; r < 2; r++) if (!pv[r]) new_req(r, 1'b0);
        step();
        n++;
      end while (!(grant_q.size() >= 4 && !m_active) && n < 300);
      chk("fair_bound", 64'(n < 300), 64'(1));
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("fair_grant%0d", i), 64'((grant_q.size() > i) ? grant_q[i] : 9), 64'(i % 2));
    drain();

    // random traffic
    rdy_pct = 70;
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < 2; r++) if (!pv[r] && $urandom_range(0, 99) < 30) new_req(r, 1'b1);
      step();
    end
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
